// File: rtl/lc2k_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Combinational only: no latency.
// No flow control of its own.
package lc2k_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_COUNT = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } load_state_t;

endpackage

// File: rtl/byte_assembler.sv
// Packs a big-endian byte stream into 32-bit words (first byte lands in [31:24]).
// o_word/o_word_vld are combinational on the 4th byte so the word is usable at its accept edge.
// No backpressure of its own; the caller gates i_byte_vld with its ready.
module byte_assembler
  import lc2k_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clr,
  input  logic              i_byte_vld,
  input  logic [7:0]        i_byte_dat,
  output logic [WORD_W-1:0] o_word,
  output logic              o_word_vld
);

  // Only the three earlier bytes need storing; the 4th comes straight from the input.
  logic [WORD_W-9:0] r_shift;
  logic [1:0]        r_cnt;

  // Shift accepted bytes in, counting 0..3 and wrapping after the 4th.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift <= '0;
      r_cnt   <= 2'd0;
    end else if (i_clr) begin
      r_shift <= '0;
      r_cnt   <= 2'd0;
    end else if (i_byte_vld) begin
      r_shift <= {r_shift[WORD_W-17:0], i_byte_dat};
      r_cnt   <= r_cnt + 2'd1;
    end
  end

  assign o_word     = {r_shift, i_byte_dat};
  assign o_word_vld = i_byte_vld && (r_cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed big-endian program image into instruction memory, holding the CPU meanwhile.
// 4th byte of a word accepted at edge k -> imem_we high during cycle k+1; cpu_hold drops the edge after the last write.
// o_in_ready is low outside COUNT/DATA; i_in_valid low simply stalls, partial words are kept.
module imem_loader
  import lc2k_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int MAX_WORDS = 2**ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_in_valid,
  input  logic [7:0]        i_in_data,
  output logic              o_in_ready,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [WORD_W-1:0] o_imem_wdata,
  output logic              o_cpu_hold,
  output logic              o_load_done,
  output logic              o_load_error
);

  localparam int             LP_CMP_W = WORD_W + 1;
  localparam logic [WORD_W:0] LP_MAX  = LP_CMP_W'(MAX_WORDS);

  load_state_t       r_state;
  load_state_t       w_state_nxt;

  logic              r_in_ready;
  logic              r_imem_we;
  logic [ADDR_W-1:0] r_imem_addr;
  logic [WORD_W-1:0] r_imem_wdata;
  logic              r_cpu_hold;
  logic              r_load_done;
  logic              r_load_error;

  // One extra bit so an image of exactly MAX_WORDS terminates cleanly.
  logic [ADDR_W:0]   r_idx;
  logic [ADDR_W:0]   r_n;
  logic [ADDR_W:0]   w_idx_inc;

  logic              w_xfer;
  logic              w_enter_count;
  logic [WORD_W-1:0] w_word;
  logic              w_word_vld;

  assign w_xfer        = i_in_valid & r_in_ready;
  assign w_enter_count = (w_state_nxt == ST_COUNT) && (r_state != ST_COUNT);
  assign w_idx_inc     = r_idx + 1'b1;

  byte_assembler u_asm (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clr      (w_enter_count),
    .i_byte_vld (w_xfer),
    .i_byte_dat (i_in_data),
    .o_word     (w_word),
    .o_word_vld (w_word_vld)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state decode; start is only honoured when no image is in flight.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (i_start) w_state_nxt = ST_COUNT;
      end
      ST_COUNT: begin
        if (w_word_vld) begin
          if (w_word == '0)                 w_state_nxt = ST_DONE;
          else if ({1'b0, w_word} > LP_MAX) w_state_nxt = ST_ERR;
          else                              w_state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_word_vld) w_state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        if (w_idx_inc == r_n) w_state_nxt = ST_DONE;
        else                  w_state_nxt = ST_DATA;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Word count and index: cleared on every new load, index advances after each write.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx <= '0;
      r_n   <= '0;
    end else if (w_enter_count) begin
      r_idx <= '0;
      r_n   <= '0;
    end else begin
      if (r_state == ST_COUNT && w_word_vld) r_n <= w_word[ADDR_W:0];
      if (r_state == ST_WRITE && w_state_nxt == ST_DATA) r_idx <= w_idx_inc;
    end
  end

  // Registered outputs, decoded from the next state so they line up with it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_in_ready   <= 1'b0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
      r_cpu_hold   <= 1'b1;
      r_load_done  <= 1'b0;
      r_load_error <= 1'b0;
    end else begin
      r_in_ready   <= (w_state_nxt == ST_COUNT) || (w_state_nxt == ST_DATA);
      r_imem_we    <= (w_state_nxt == ST_WRITE);
      r_cpu_hold   <= (w_state_nxt != ST_DONE);
      r_load_done  <= (w_state_nxt == ST_DONE);
      r_load_error <= (w_state_nxt == ST_ERR);
      if (w_state_nxt == ST_WRITE && r_state != ST_WRITE) begin
        r_imem_addr  <= r_idx[ADDR_W-1:0];
        r_imem_wdata <= w_word;
      end
    end
  end

  assign o_in_ready   = r_in_ready;
  assign o_imem_we    = r_imem_we;
  assign o_imem_addr  = r_imem_addr;
  assign o_imem_wdata = r_imem_wdata;
  assign o_cpu_hold   = r_cpu_hold;
  assign o_load_done  = r_load_done;
  assign o_load_error = r_load_error;

endmodule
